// File: rtl/led_rate_select.sv
// led_rate_select: debounced push-button steps a rate-select FSM
// that routes one blinker wave, or off, to the board LED.
module led_rate_select #(
  parameter int g_DEBOUNCE_LIMIT = 250000,
  parameter int g_LONG_PRESS     = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  input  logic       i_LED_1,
  input  logic       i_LED_2,
  input  logic       i_LED_3,
  input  logic       i_LED_4,
  output logic       o_LED,
  output logic [2:0] o_Mode,
  output logic       o_Press
);

  localparam int CW = $clog2(g_DEBOUNCE_LIMIT);
  localparam int HW = $clog2(g_LONG_PRESS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(g_DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(g_LONG_PRESS);

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    HZ1  = 3'd1,
    HZ2  = 3'd2,
    HZ5  = 3'd3,
    HZ10 = 3'd4
  } mode_t;

  logic          r_Sync1;
  logic          r_Sync2;
  logic          r_Deb;
  logic          r_Deb_d;
  logic [CW-1:0] r_Cnt;
  logic [HW-1:0] r_Hold;
  logic          r_Long;
  mode_t         r_Mode;

  mode_t         mode_nxt;
  logic          long_nxt;
  logic          press_nxt;
  logic          led_sel;
  logic          long_hit;
  logic          deb_fall;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync1 <= 1'b0;
      r_Sync2 <= 1'b0;
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Deb   <= 1'b0;
      r_Deb_d <= 1'b0;
      r_Cnt   <= '0;
    end else begin
      r_Deb_d <= r_Deb;
      if (r_Sync2 == r_Deb) begin
        r_Cnt <= '0;
      end else if (r_Cnt == CNT_MAX) begin
        r_Deb <= r_Sync2;
        r_Cnt <= '0;
      end else begin
        r_Cnt <= r_Cnt + CW'(1);
      end
    end
  end

  // Saturating hold time of the debounced level
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Hold <= '0;
    end else if (!r_Deb) begin
      r_Hold <= '0;
    end else if (r_Hold != HOLD_MAX) begin
      r_Hold <= r_Hold + HW'(1);
    end
  end

  assign long_hit = (r_Hold == HOLD_MAX) && !r_Long;
  assign deb_fall = r_Deb_d && !r_Deb;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Mode  <= OFF;
      r_Long  <= 1'b0;
      o_Press <= 1'b0;
    end else begin
      r_Mode  <= mode_nxt;
      r_Long  <= long_nxt;
      o_Press <= press_nxt;
    end
  end

  // A release coinciding with the long hit is consumed by it
  always_comb begin
    mode_nxt  = r_Mode;
    long_nxt  = r_Long;
    press_nxt = 1'b0;
    if (long_hit) begin
      mode_nxt = OFF;
      long_nxt = r_Deb;
    end else if (deb_fall) begin
      long_nxt = 1'b0;
      if (!r_Long) begin
        press_nxt = 1'b1;
        case (r_Mode)
          OFF:     mode_nxt = HZ1;
          HZ1:     mode_nxt = HZ2;
          HZ2:     mode_nxt = HZ5;
          HZ5:     mode_nxt = HZ10;
          HZ10:    mode_nxt = OFF;
          default: mode_nxt = HZ1;
        endcase
      end
    end
  end

  always_comb begin
    led_sel = 1'b0;
    unique case (1'b1)
      r_Mode == HZ1:  led_sel = i_LED_4;
      r_Mode == HZ2:  led_sel = i_LED_3;
      r_Mode == HZ5:  led_sel = i_LED_2;
      r_Mode == HZ10: led_sel = i_LED_1;
      default:        led_sel = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_LED <= 1'b0;
    end else begin
      o_LED <= led_sel;
    end
  end

  assign o_Mode = r_Mode;

endmodule

// File: tb/tb_led_rate_select.sv
// tb_led_rate_select: random and directed button stimulus checked
// every cycle against a behavioural model of the mode selector.
module tb_led_rate_select;

  localparam int DL = 4;
  localparam int LP = 20;

  logic       i_Clk    = 1'b0;
  logic       i_Rst_L  = 1'b0;
  logic       i_Switch = 1'b0;
  logic       i_LED_1  = 1'b0;
  logic       i_LED_2  = 1'b0;
  logic       i_LED_3  = 1'b0;
  logic       i_LED_4  = 1'b0;
  logic       o_LED;
  logic [2:0] o_Mode;
  logic       o_Press;

  int checks    = 0;
  int failures  = 0;
  int press_cnt = 0;
  int blink_cyc = 0;
  bit prev_press = 1'b0;

  int m_mode;
  bit m_led;
  bit m_press;
  bit m_deb;
  int hi_edges;
  bit sw_q[$];
  bit syn_q[$];

  led_rate_select #(
    .g_DEBOUNCE_LIMIT(DL),
    .g_LONG_PRESS(LP)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Switch(i_Switch),
    .i_LED_1(i_LED_1),
    .i_LED_2(i_LED_2),
    .i_LED_3(i_LED_3),
    .i_LED_4(i_LED_4),
    .o_LED(o_LED),
    .o_Mode(o_Mode),
    .o_Press(o_Press)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit led_of(input int md);
    case (md)
      1:       return i_LED_4;
      2:       return i_LED_3;
      3:       return i_LED_2;
      4:       return i_LED_1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_mode   = 0;
    m_led    = 1'b0;
    m_press  = 1'b0;
    m_deb    = 1'b0;
    hi_edges = 0;
    sw_q.delete();
    repeat (2) sw_q.push_back(1'b0);
    syn_q.delete();
    repeat (DL) syn_q.push_back(1'b0);
  endtask

  // Model: debounced level flips once the synced button has
  // disagreed with it for DL straight samples; a press is long
  // once the debounced level has been high for LP edges.
  initial begin
    bit s;
    bit flip;
    bit nled;
    m_reset();
    forever begin
      @(posedge i_Clk or negedge i_Rst_L);
      if (!i_Rst_L) begin
        m_reset();
      end else begin
        s = sw_q[1];
        sw_q.push_front(i_Switch);
        void'(sw_q.pop_back());
        syn_q.push_front(s);
        void'(syn_q.pop_back());
        nled = led_of(m_mode);
        m_press = 1'b0;
        if (hi_edges == LP) begin
          m_mode = 0;
        end else if (!m_deb && hi_edges > 0 && hi_edges < LP) begin
          m_mode  = (m_mode + 1) % 5;
          m_press = 1'b1;
        end
        m_led = nled;
        hi_edges = m_deb ? hi_edges + 1 : 0;
        flip = 1'b1;
        foreach (syn_q[i]) if (syn_q[i] == m_deb) flip = 1'b0;
        if (flip) m_deb = !m_deb;
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_Clk);
      chk("o_Mode", int'(o_Mode), m_mode);
      chk("o_LED", int'(o_LED), int'(m_led));
      chk("o_Press", int'(o_Press), int'(m_press));
      chk("press_twice", int'(o_Press && prev_press), 0);
      prev_press = o_Press;
      if (o_Press) press_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge i_Clk);
      #1;
      blink_cyc++;
      if (blink_cyc % 5 == 0)  i_LED_1 = ~i_LED_1;
      if (blink_cyc % 10 == 0) i_LED_2 = ~i_LED_2;
      if (blink_cyc % 25 == 0) i_LED_3 = ~i_LED_3;
      if (blink_cyc % 50 == 0) i_LED_4 = ~i_LED_4;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge i_Clk);
      #2;
    end
  endtask

  task automatic press(input int hi, input int lo);
    i_Switch = 1'b1;
    step(hi);
    i_Switch = 1'b0;
    step(lo);
  endtask

  initial begin
    int wrap_exp[5];
    int pc;
    bit l3;
    wrap_exp = '{1, 2, 3, 4, 0};

    i_Rst_L = 1'b0;
    repeat (5) begin
      i_Switch = ~i_Switch;
      step(1);
      chk("rst_mode", int'(o_Mode), 0);
      chk("rst_led", int'(o_LED), 0);
      chk("rst_press", int'(o_Press), 0);
    end
    i_Switch = 1'b0;
    step(2);
    i_Rst_L = 1'b1;
    step(10);
    chk("post_rst_mode", int'(o_Mode), 0);

    for (int w = 1; w <= 3; w++) begin
      i_Switch = 1'b1;
      step(w);
      i_Switch = 1'b0;
      step(1);
    end
    step(10);
    chk("bounce_mode", int'(o_Mode), 0);
    chk("bounce_press", press_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      press(8, 8);
      chk("wrap_mode", int'(o_Mode), wrap_exp[i]);
    end
    chk("wrap_presses", press_cnt, 5);

    press(8, 8);
    chk("lat_start", int'(o_Mode), 1);
    i_Switch = 1'b1;
    step(8);
    i_Switch = 1'b0;
    step(DL + 2);
    chk("lat_before", int'(o_Mode), 1);
    step(1);
    chk("lat_at", int'(o_Mode), 2);
    l3 = i_LED_3;
    step(1);
    chk("lat_led", int'(o_LED), int'(l3));
    step(8);

    press(8, 8);
    chk("long_start", int'(o_Mode), 3);
    pc = press_cnt;
    i_Switch = 1'b1;
    step(30);
    chk("long_held", int'(o_Mode), 0);
    i_Switch = 1'b0;
    step(10);
    chk("long_rel", int'(o_Mode), 0);
    chk("long_nopress", press_cnt, pc);
    press(8, 8);
    chk("long_next", int'(o_Mode), 1);

    pc = press_cnt;
    press(LP, 10);
    chk("edge_lp", int'(o_Mode), 0);
    chk("edge_lp_press", press_cnt, pc);
    press(LP - 1, 10);
    chk("edge_lp_m1", int'(o_Mode), 1);
    chk("edge_lp_m1_press", press_cnt, pc + 1);

    i_Switch = 1'b1;
    step(2);
    i_Rst_L = 1'b0;
    step(1);
    chk("mid_rst_mode", int'(o_Mode), 0);
    step(2);
    i_Rst_L = 1'b1;
    step(2);
    i_Switch = 1'b0;
    step(12);
    chk("mid_rst_short", int'(o_Mode), 0);

    i_Switch = 1'b1;
    i_Rst_L = 1'b0;
    step(2);
    i_Rst_L = 1'b1;
    step(DL);
    chk("mid_rst_held", int'(o_Mode), 0);
    step(4);
    i_Switch = 1'b0;
    step(10);
    chk("mid_rst_rel", int'(o_Mode), 1);

    repeat (150) begin
      if ($urandom_range(0, 19) == 0) begin
        i_Rst_L = 1'b0;
        step($urandom_range(1, 3));
        i_Rst_L = 1'b1;
      end else begin
        i_Switch = 1'($urandom_range(0, 1));
        step($urandom_range(1, 30));
      end
    end
    i_Switch = 1'b0;
    step(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
